lsu_mem_port: RTL
=================

Name: lsu_mem_port

Overview:
- Memory-side responder for the load/store controls produced by instruction decode: MemRw, LoadStoreMode (funct3) and WBSel=00 loads.
- Converts one core load/store into a single word-aligned bus transaction.
  - Stores: byte enables and lane-shifted write data.
  - Loads: lane extraction plus sign/zero extension.
- Holds the core in stall until the bus acknowledges, the access is rejected as misaligned, or the access times out.

Parameters:
- AW, 32, byte address width.
- TIMEOUT, 255, bus_ack wait limit in cycles (1..65535); counter width $clog2(TIMEOUT+1).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mem_en  input  1  core requests an access this cycle (load or store opcode).
- MemRw  input  1  1=store, 0=load.
- LoadStoreMode  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  input  AW  byte address (ALU result).
- wdata  input  32  store data (rs2).
- rdata  output  32  extended load result, registered.
- stall  output  1  core must hold PC and inputs.
- misalign  output  1  one-cycle pulse: access rejected.
- fault  output  1  one-cycle pulse: bad mode or timeout.
- bus_req  output  1  transaction valid.
- bus_we  output  1  write.
- bus_addr  output  AW  {addr[AW-1:2],2'b00}.
- bus_be  output  4  byte enables.
- bus_wdata  output  32  lane-aligned write data.
- bus_rdata  input  32  read word, valid with bus_ack.
- bus_ack  input  1  transaction complete.

Behaviour:
- Reset (async, rst_n=0): state IDLE; rdata=0, stall=0, misalign=0, fault=0, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, timeout counter=0.
- States: IDLE, BUS, DONE.
- IDLE, mem_en=0: outputs idle, stall=0.
- IDLE, mem_en=1, access checks:
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
    - misalign=1 next cycle; no bus activity; stay IDLE.
    - stall is combinationally 1 during the request cycle only.
  - Invalid mode: 011, 110, 111, or store with mode bit2=1.
    - fault=1 next cycle; no bus activity; stay IDLE.
  - Valid access:
    - Latch mode, addr[1:0] and MemRw; go to BUS.
    - Assert bus_req with registered bus_addr/bus_be/bus_we/bus_wdata; stall=1 combinationally from the request cycle onward.
- Byte enables:
  - B: 4'b0001<<addr[1:0].
  - H: 4'b0011<<addr[1:0].
  - W: 4'b1111.
  - Loads drive the same enables with bus_we=0.
- Write data:
  - B replicates wdata[7:0] to all four lanes.
  - H replicates wdata[15:0] to both halves.
  - W passes wdata through.
- BUS: bus_req and all bus outputs held stable until bus_ack; counter increments each cycle.
  - bus_ack=1:
    - Load: capture rdata from lane (byte addr[1:0] / half addr[1]).
      - B/H sign-extend bit 7/15; BU/HU zero-extend.
    - Store: rdata unchanged.
    - Drop bus_req; go to DONE.
  - counter==TIMEOUT without ack: drop bus_req, fault=1 next cycle, rdata unchanged, go to DONE.
  - bus_ack in the same cycle the counter reaches TIMEOUT: ack wins, no fault.
- DONE: stall=0 for one cycle, which releases the core; return to IDLE.
  - mem_en in DONE is ignored; the core re-presents next cycle.
  - Load-to-use latency: rdata valid in DONE, 2 cycles after the request when ack arrives on the first BUS cycle.
- bus_ack while not in BUS: ignored.
- Reset mid-transaction: immediate return to reset values; the pending bus transaction is abandoned and bus_req is deasserted asynchronously.
- rdata holds its last load value across stores and idle cycles.

Decomposition:
- Shared package (lsu_pkg):
  - LoadStoreMode encodings LS_B/LS_H/LS_W/LS_BU/LS_HU.
  - FSM state enum.
  - MEMRW_LOAD/MEMRW_STORE constants, also reused by the control decoder.
- One natural sub-module: lsu_lane_align, purely combinational.
  - Inputs: mode, offset, wdata, bus_rdata.
  - Outputs: be, shifted wdata, extended load data.
- The FSM and timeout counter stay in lsu_mem_port.

Test Plan:
- Store B: mode=000, addr=0x1003, wdata=0xA5 → bus_addr=0x1000, be=1000, bus_wdata=0xA5A5A5A5, bus_we=1; ack after 3 cycles → stall drops in DONE, no fault.
- Load B signed and unsigned: bus_rdata=0x80FF7F01, addr=0x2002.
  - mode=000 → rdata=0xFFFFFFFF.
  - mode=100 → rdata=0x000000FF.
  - addr=0x2003, mode=000 → rdata=0xFFFFFF80.
- Load H/HU: bus_rdata=0x8001_7FFE, addr offset 2.
  - mode=001 → rdata=0xFFFF8001.
  - mode=101 → rdata=0x00008001.
  - offset 0, mode=001 → rdata=0x00007FFE.
- Misalign: LW addr=0x3002, and SH addr=0x3001 → misalign pulse, bus_req never asserts, rdata unchanged.
- Timeout: TIMEOUT=4, no ack → fault pulse after 4 BUS cycles, bus_req drops.
  - Repeat with ack on the 4th cycle → no fault, rdata captured.
- Reset mid-BUS: rst_n low while bus_req=1 → all outputs 0 immediately.
  - After release, a new LW at 0x0 with ack=0x12345678 → rdata=0x12345678.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared load/store encodings, FSM state and access checks
package lsu_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    localparam logic MEMRW_LOAD  = 1'b0;
    localparam logic MEMRW_STORE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    // Unsigned widths exist only for loads; 011/110/111 are never legal.
    function automatic logic mode_valid(input logic [2:0] mode, input logic rw);
        case (mode)
            LS_B, LS_H, LS_W: return 1'b1;
            LS_BU, LS_HU:     return (rw == MEMRW_LOAD);
            default:          return 1'b0;
        endcase
    endfunction

    // Halfwords need even addresses, words need 4-byte alignment.
    function automatic logic addr_misaligned(input logic [2:0] mode, input logic [1:0] off);
        case (mode)
            LS_H, LS_HU: return off[0];
            LS_W:        return (off != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte enables, store lane replication and load extension
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  mode_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword out of the bus word.
    always_comb begin
        byte_sel = rdata_i[7:0];
        case (offset_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase
        half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Size-dependent enables, replicated store data and extended load data.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        load_o  = 32'h0;
        case (mode_i)
            LS_B, LS_BU: begin
                be_o    = 4'b0001 << offset_i;
                wdata_o = {4{wdata_i[7:0]}};
                load_o  = mode_i[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            LS_H, LS_HU: begin
                be_o    = 4'b0011 << offset_i;
                wdata_o = {2{wdata_i[15:0]}};
                load_o  = mode_i[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            LS_W: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                load_o  = rdata_i;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = 32'h0;
                load_o  = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - single-transaction load/store bus port with stall, misalign and timeout
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mem_en,
    input  logic          MemRw,
    input  logic [2:0]    LoadStoreMode,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          stall,
    output logic          misalign,
    output logic          fault,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [3:0]    bus_be,
    output logic [31:0]   bus_wdata,
    input  logic [31:0]   bus_rdata,
    input  logic          bus_ack
);

    localparam int            CW  = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    lsu_state_e    state_q;
    logic [2:0]    mode_q;
    logic [1:0]    off_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [31:0]   rdata_q;
    logic          misalign_q;
    logic          fault_q;
    logic          bus_req_q;
    logic          bus_we_q;
    logic [AW-1:0] bus_addr_q;
    logic [3:0]    bus_be_q;
    logic [31:0]   bus_wdata_q;

    logic          req_valid_mode;
    logic          req_misaligned;
    logic [2:0]    al_mode;
    logic [1:0]    al_off;
    logic [3:0]    al_be;
    logic [31:0]   al_wdata;
    logic [31:0]   al_load;

    // The aligner serves the request in IDLE and the captured access while on the bus.
    always_comb begin
        al_mode        = (state_q == ST_BUS) ? mode_q : LoadStoreMode;
        al_off         = (state_q == ST_BUS) ? off_q  : addr[1:0];
        req_valid_mode = mode_valid(LoadStoreMode, MemRw);
        req_misaligned = addr_misaligned(LoadStoreMode, addr[1:0]);
        cnt_d          = cnt_q + CW'(1);
        stall          = ((state_q == ST_IDLE) && mem_en) || (state_q == ST_BUS);
    end

    lsu_lane_align u_align (
        .mode_i   (al_mode),
        .offset_i (al_off),
        .wdata_i  (wdata),
        .rdata_i  (bus_rdata),
        .be_o     (al_be),
        .wdata_o  (al_wdata),
        .load_o   (al_load)
    );

    // Access FSM: accept or reject in IDLE, wait for ack or timeout in BUS, release in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= 3'b000;
            off_q       <= 2'b00;
            cnt_q       <= '0;
            rdata_q     <= 32'h0;
            misalign_q  <= 1'b0;
            fault_q     <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'h0;
        end else begin
            misalign_q <= 1'b0;
            fault_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (mem_en) begin
                        if (!req_valid_mode) begin
                            fault_q <= 1'b1;
                        end else if (req_misaligned) begin
                            misalign_q <= 1'b1;
                        end else begin
                            state_q     <= ST_BUS;
                            mode_q      <= LoadStoreMode;
                            off_q       <= addr[1:0];
                            cnt_q       <= '0;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= MemRw;
                            bus_addr_q  <= {addr[AW-1:2], 2'b00};
                            bus_be_q    <= al_be;
                            bus_wdata_q <= (MemRw == MEMRW_STORE) ? al_wdata : 32'h0;
                        end
                    end
                end
                ST_BUS: begin
                    if (bus_ack || (cnt_d == TMO)) begin
                        // Ack takes priority over a timeout landing in the same cycle.
                        if (bus_ack && (bus_we_q == MEMRW_LOAD)) begin
                            rdata_q <= al_load;
                        end
                        fault_q     <= !bus_ack;
                        state_q     <= ST_DONE;
                        cnt_q       <= '0;
                        bus_req_q   <= 1'b0;
                        bus_we_q    <= 1'b0;
                        bus_addr_q  <= '0;
                        bus_be_q    <= 4'b0000;
                        bus_wdata_q <= 32'h0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rdata     = rdata_q;
    assign misalign  = misalign_q;
    assign fault     = fault_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule
